hazard_forward_ctrl: RTL and testbench

Pipeline hazard and forwarding controller for the 5-stage MIPS datapath. Drives the 2-bit select inputs of the two EX-stage 32-bit 3:1 operand muxes (00 = register-file value, 01 = WB-stage result, 10 = MEM-stage result). Detects load-use and branch-operand hazards and issues stall/bubble controls to the PC, IF/ID and ID/EX registers. It keeps its own shadow copy of destination and source register tags for EX, MEM and WB, so the datapath only supplies ID-stage decode information.

---
 rtl/hazard_forward_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and EX operand forwarding for the 5-stage pipeline.
// Tracks EX/MEM/WB register tags internally; the datapath only supplies ID decode.
module hazard_forward_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [4:0]             id_dest,
  input  logic                   id_reg_write,
  input  logic                   id_mem_read,
  input  logic                   id_is_branch,
  input  logic                   flush,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   idex_bubble,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       reg_write;
    logic       mem_read;
  } prod_t;

  typedef struct packed {
    prod_t      p;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } ex_t;

  // WB only ever forwards, so its load flag is never consulted.
  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       reg_write;
  } wb_t;

  ex_t   ex_q;
  ex_t   ex_d;
  prod_t mem_q;
  wb_t   wb_q;

  logic stall;
  logic id_hit_ex;
  logic id_hit_mem;
  logic load_use;
  logic br_ex;
  logic br_mem;

  function automatic logic hit(
    input logic       v,
    input logic       rw,
    input logic [4:0] d,
    input logic [4:0] s,
    input logic       u
  );
    return v && rw && (d == s) && (d != 5'd0) && u;
  endfunction

  assign id_hit_ex =
    hit(ex_q.p.valid, ex_q.p.reg_write, ex_q.p.dest,
        id_rs, id_uses_rs) ||
    hit(ex_q.p.valid, ex_q.p.reg_write, ex_q.p.dest,
        id_rt, id_uses_rt);

  assign id_hit_mem =
    hit(mem_q.valid, mem_q.reg_write, mem_q.dest,
        id_rs, id_uses_rs) ||
    hit(mem_q.valid, mem_q.reg_write, mem_q.dest,
        id_rt, id_uses_rt);

  assign load_use = ex_q.p.mem_read && id_hit_ex;
  assign br_ex    = id_is_branch && id_hit_ex;
  // An ALU result in MEM reaches the branch comparator; load data does not yet.
  assign br_mem   = id_is_branch && mem_q.mem_read && id_hit_mem;

  assign stall = id_valid && !flush &&
                 (load_use || br_ex || br_mem);

  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign idex_bubble = stall;

  always_comb begin
    ex_d = '0;
    if (id_valid && !stall && !flush) begin
      ex_d.p.valid     = 1'b1;
      ex_d.p.dest      = id_dest;
      ex_d.p.reg_write = id_reg_write;
      ex_d.p.mem_read  = id_mem_read;
      ex_d.rs          = id_rs;
      ex_d.rt          = id_rt;
      ex_d.uses_rs     = id_uses_rs;
      ex_d.uses_rt     = id_uses_rt;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q           <= ex_d;
      mem_q          <= ex_q.p;
      wb_q.valid     <= mem_q.valid;
      wb_q.dest      <= mem_q.dest;
      wb_q.reg_write <= mem_q.reg_write;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    priority case (1'b1)
      hit(mem_q.valid, mem_q.reg_write, mem_q.dest,
          ex_q.rs, ex_q.uses_rs): fwd_a = 2'b10;
      hit(wb_q.valid, wb_q.reg_write, wb_q.dest,
          ex_q.rs, ex_q.uses_rs): fwd_a = 2'b01;
      default:                    fwd_a = 2'b00;
    endcase
  end

  always_comb begin
    fwd_b = 2'b00;
    priority case (1'b1)
      hit(mem_q.valid, mem_q.reg_write, mem_q.dest,
          ex_q.rt, ex_q.uses_rt): fwd_b = 2'b10;
      hit(wb_q.valid, wb_q.reg_write, wb_q.dest,
          ex_q.rt, ex_q.uses_rt): fwd_b = 2'b01;
      default:                    fwd_b = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl.
// Second narrow instance exercises counter saturation cheaply.
module tb_hazard_forward_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  id_dest;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_is_branch;
  logic        flush;
  logic        pc_write;
  logic        ifid_write;
  logic        idex_bubble;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_count;

  logic        s_pc_write;
  logic        s_ifid_write;
  logic        s_idex_bubble;
  logic [1:0]  s_fwd_a;
  logic [1:0]  s_fwd_b;
  logic [7:0]  s_stall_count;

  int checks = 0;
  int errors = 0;

  hazard_forward_ctrl #(.STALL_CNT_W(16)) dut (
    .Clk(clk), .Rst(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_is_branch(id_is_branch),
    .flush(flush),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count)
  );

  hazard_forward_ctrl #(.STALL_CNT_W(8)) sat_dut (
    .Clk(clk), .Rst(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_is_branch(id_is_branch),
    .flush(flush),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .idex_bubble(s_idex_bubble),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v,
                        input logic [4:0] rs,
                        input logic [4:0] rt,
                        input logic urs,
                        input logic urt,
                        input logic [4:0] d,
                        input logic rw,
                        input logic mr,
                        input logic br);
    id_valid     = v;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_dest      = d;
    id_reg_write = rw;
    id_mem_read  = mr;
    id_is_branch = br;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] rd,
                     input logic [4:0] rs,
                     input logic [4:0] rt);
    set_id(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [4:0] rt,
                      input logic [4:0] base);
    set_id(1'b1, base, rt, 1'b1, 1'b0, rt, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic beq(input logic [4:0] rs,
                     input logic [4:0] rt);
    set_id(1'b1, rs, rt, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    nop();
    #3;
    chk("rst_pc_write", 32'(pc_write), 32'd1);
    chk("rst_ifid_write", 32'(ifid_write), 32'd1);
    chk("rst_bubble", 32'(idex_bubble), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_fwd_b", 32'(fwd_b), 32'd0);
    chk("rst_count", 32'(stall_count), 32'd0);
    chk("rst_sat_count", 32'(s_stall_count), 32'd0);
    #9;
    rst_n = 1'b1;
    tick();

    // add $3 -> sub $4,$3,$5 : MEM forward
    alu(5'd3, 5'd1, 5'd2);
    tick();
    alu(5'd4, 5'd3, 5'd5);
    #2;
    chk("alu_alu_nostall", 32'(pc_write), 32'd1);
    tick();
    chk("fwd_mem_a", 32'(fwd_a), 32'd2);
    chk("fwd_mem_b", 32'(fwd_b), 32'd0);

    // one nop between : WB forward
    alu(5'd3, 5'd1, 5'd2);
    tick();
    nop();
    tick();
    alu(5'd4, 5'd3, 5'd5);
    tick();
    chk("fwd_wb_a", 32'(fwd_a), 32'd1);

    // two nops : register file
    alu(5'd3, 5'd1, 5'd2);
    tick();
    nop();
    tick();
    tick();
    alu(5'd4, 5'd3, 5'd5);
    tick();
    chk("fwd_none_a", 32'(fwd_a), 32'd0);

    // double hit : MEM wins
    alu(5'd3, 5'd1, 5'd2);
    tick();
    alu(5'd3, 5'd1, 5'd2);
    tick();
    alu(5'd6, 5'd3, 5'd3);
    tick();
    chk("dbl_fwd_a", 32'(fwd_a), 32'd2);
    chk("dbl_fwd_b", 32'(fwd_b), 32'd2);
    drain();

    // load-use
    load(5'd2, 5'd1);
    tick();
    alu(5'd4, 5'd2, 5'd2);
    #2;
    chk("lu_pc_write", 32'(pc_write), 32'd0);
    chk("lu_ifid_write", 32'(ifid_write), 32'd0);
    chk("lu_bubble", 32'(idex_bubble), 32'd1);
    tick();
    #2;
    chk("lu_release", 32'(pc_write), 32'd1);
    chk("lu_release_bub", 32'(idex_bubble), 32'd0);
    chk("lu_count", 32'(stall_count), 32'd1);
    tick();
    chk("lu_fwd_a", 32'(fwd_a), 32'd1);
    chk("lu_fwd_b", 32'(fwd_b), 32'd1);
    drain();

    // branch after ALU : 1 stall
    alu(5'd5, 5'd1, 5'd2);
    tick();
    beq(5'd5, 5'd0);
    #2;
    chk("br_alu_stall", 32'(pc_write), 32'd0);
    tick();
    #2;
    chk("br_alu_release", 32'(pc_write), 32'd1);
    chk("br_alu_count", 32'(stall_count), 32'd2);
    tick();
    drain();

    // branch after load : 2 stalls
    load(5'd5, 5'd1);
    tick();
    beq(5'd5, 5'd0);
    #2;
    chk("br_ld_stall1", 32'(pc_write), 32'd0);
    tick();
    #2;
    chk("br_ld_stall2", 32'(ifid_write), 32'd0);
    chk("br_ld_stall2_bub", 32'(idex_bubble), 32'd1);
    tick();
    #2;
    chk("br_ld_release", 32'(pc_write), 32'd1);
    chk("br_ld_count", 32'(stall_count), 32'd4);
    tick();
    drain();

    // register zero
    alu(5'd0, 5'd1, 5'd2);
    tick();
    alu(5'd4, 5'd0, 5'd0);
    #2;
    chk("r0_nostall", 32'(pc_write), 32'd1);
    tick();
    chk("r0_fwd_a", 32'(fwd_a), 32'd0);
    chk("r0_fwd_b", 32'(fwd_b), 32'd0);
    load(5'd0, 5'd1);
    tick();
    alu(5'd4, 5'd0, 5'd0);
    #2;
    chk("r0_load_nostall", 32'(idex_bubble), 32'd0);
    tick();
    drain();

    // flush overrides load-use; squashed add never reaches EX
    load(5'd2, 5'd1);
    tick();
    alu(5'd4, 5'd2, 5'd2);
    flush = 1'b1;
    #2;
    chk("flush_pc_write", 32'(pc_write), 32'd1);
    chk("flush_bubble", 32'(idex_bubble), 32'd0);
    tick();
    flush = 1'b0;
    beq(5'd4, 5'd4);
    #2;
    chk("flush_ex_bubble", 32'(pc_write), 32'd1);
    chk("flush_count", 32'(stall_count), 32'd4);
    tick();
    drain();

    // async reset in the middle of a stall
    alu(5'd1, 5'd3, 5'd3);
    tick();
    load(5'd2, 5'd1);
    tick();
    alu(5'd4, 5'd2, 5'd2);
    #2;
    chk("mid_fwd_a", 32'(fwd_a), 32'd2);
    chk("mid_stall", 32'(pc_write), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pc_write", 32'(pc_write), 32'd1);
    chk("mid_rst_bubble", 32'(idex_bubble), 32'd0);
    chk("mid_rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("mid_rst_count", 32'(stall_count), 32'd0);
    nop();
    tick();
    rst_n = 1'b1;
    tick();

    // saturation: load+branch pattern gives 2 stalls every 3 cycles
    set_id(1'b1, 5'd2, 5'd0, 1'b1, 1'b0,
           5'd2, 1'b1, 1'b1, 1'b1);
    repeat (600) tick();
    chk("sat_wide_count", 32'(stall_count), 32'd400);
    chk("sat_narrow_count", 32'(s_stall_count), 32'd255);
    repeat (6) tick();
    chk("sat_narrow_hold", 32'(s_stall_count), 32'd255);
    chk("sat_wide_more", 32'(stall_count), 32'd404);
    nop();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
